// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encodings, coin codes
// and default denomination values.
package change_dispenser_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_CALC     = 2'd1;
  localparam state_t ST_DISPENSE = 2'd2;
  localparam state_t ST_DONE     = 2'd3;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_LO   = 2'b01;
  localparam logic [1:0] CODE_MID  = 2'b10;
  localparam logic [1:0] CODE_HI   = 2'b11;

  localparam int unsigned DEF_COIN_HI  = 10;
  localparam int unsigned DEF_COIN_MID = 5;
  localparam int unsigned DEF_COIN_LO  = 1;

endpackage

// File: rtl/change_dispenser_alu.sv
// W-bit ADD/SUB unit. Subtraction is a (W+1)-bit add of a, ~b and carry-in 1;
// a clear carry-out on a subtract is reported as a borrow.
module alu_addsub5 #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_result,
  output logic         o_borrow
);

  logic [W-1:0] w_b_eff;
  logic [W:0]   w_sum;

  assign w_b_eff  = i_sub ? ~i_b : i_b;
  assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{W{1'b0}}, i_sub};
  assign o_result = w_sum[W-1:0];
  assign o_borrow = i_sub & ~w_sum[W];

endmodule

// File: rtl/change_dispenser.sv
// Change-return unit: computes credit - price, flags insufficient credit, and
// hands out the change one coin per valid/ready handshake, largest coin first.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned W        = 5,
  parameter int unsigned COIN_HI  = DEF_COIN_HI,
  parameter int unsigned COIN_MID = DEF_COIN_MID,
  parameter int unsigned COIN_LO  = DEF_COIN_LO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] credit,
  input  logic [W-1:0] price,
  output logic         busy,
  output logic         coin_valid,
  input  logic         coin_ready,
  output logic [1:0]   coin_code,
  output logic [W-1:0] change_total,
  output logic         done,
  output logic         insufficient
);

  localparam logic [W-1:0] HI_W  = W'(COIN_HI);
  localparam logic [W-1:0] MID_W = W'(COIN_MID);
  localparam logic [W-1:0] LO_W  = W'(COIN_LO);

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_credit;
  logic [W-1:0] r_price;
  logic [W-1:0] r_remaining;
  logic [W-1:0] r_change_total;
  logic         r_done;
  logic         r_insufficient;

  logic [W-1:0] w_denom;
  logic [1:0]   w_denom_code;
  logic [W-1:0] w_alu_a;
  logic [W-1:0] w_alu_b;
  logic [W-1:0] w_alu_diff;
  logic         w_alu_borrow;
  logic         w_in_calc;
  logic         w_in_dispense;
  logic         w_handshake;

  assign w_in_calc     = (r_state == ST_CALC);
  assign w_in_dispense = (r_state == ST_DISPENSE);
  assign w_handshake   = w_in_dispense & coin_ready;

  // Largest coin not exceeding the registered remainder; remainder is never 0 here.
  always_comb begin
    w_denom      = LO_W;
    w_denom_code = CODE_LO;
    if (r_remaining >= HI_W) begin
      w_denom      = HI_W;
      w_denom_code = CODE_HI;
    end else if (r_remaining >= MID_W) begin
      w_denom      = MID_W;
      w_denom_code = CODE_MID;
    end
  end

  // One subtractor serves both the change computation and the per-coin decrement.
  assign w_alu_a = w_in_calc ? r_credit : r_remaining;
  assign w_alu_b = w_in_calc ? r_price  : w_denom;

  alu_addsub5 #(
    .W (W)
  ) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_sub    (1'b1),
    .o_result (w_alu_diff),
    .o_borrow (w_alu_borrow)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_CALC;
      end
      ST_CALC: begin
        if (w_alu_borrow || (w_alu_diff == '0)) w_state_next = ST_DONE;
        else                                    w_state_next = ST_DISPENSE;
      end
      ST_DISPENSE: begin
        if (w_handshake && (w_alu_diff == '0)) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_price        <= '0;
      r_remaining    <= '0;
      r_change_total <= '0;
      r_done         <= 1'b0;
      r_insufficient <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_done         <= (w_state_next == ST_DONE);
      r_insufficient <= (w_state_next == ST_DONE) & w_in_calc & w_alu_borrow;
      if ((r_state == ST_IDLE) && start) begin
        r_credit       <= credit;
        r_price        <= price;
        r_change_total <= '0;
      end
      if (w_in_calc && !w_alu_borrow && (w_alu_diff != '0)) begin
        r_remaining    <= w_alu_diff;
        r_change_total <= w_alu_diff;
      end
      if (w_handshake) begin
        r_remaining <= w_alu_diff;
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign coin_valid   = w_in_dispense;
  assign coin_code    = w_in_dispense ? w_denom_code : CODE_NONE;
  assign change_total = r_change_total;
  assign done         = r_done;
  assign insufficient = r_insufficient;

endmodule
